// File: rtl/asteroids_pkg.sv
// Shared screen geometry and redraw FSM encoding for the asteroids movement datapath.
// Edge behaviour of every tracker is selected by the POS_WRAP_EN macro (wrap when defined, saturate otherwise).
package asteroids_pkg;

    localparam int SCREEN_W = 160;
    localparam int SCREEN_H = 120;
    localparam int X_W_DEF  = 8;
    localparam int Y_W_DEF  = 7;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_REQ   = 2'd1,
        S_ACKED = 2'd2
    } redraw_state_e;

endpackage

// File: rtl/position_tracker_axis_step.sv
// axis_step: next value of one screen coordinate from spawn, step and sign.
// Macro POS_WRAP_EN: defined = toroidal wrap at 0/MAX, undefined = saturate at 0/MAX.
module axis_step #(
    parameter int W   = 8,
    parameter int MAX = 159
) (
    input  logic [W-1:0] pos_i,
    input  logic         step_i,
    input  logic         sign_i,
    input  logic         spawn_i,
    input  logic [W-1:0] spawn_val_i,
    output logic [W-1:0] next_pos_o
);

    localparam logic [W-1:0] MAX_V = W'(MAX);
    localparam logic [W-1:0] ONE_V = W'(1);

    // NOTE: default first so no path through this block infers a latch.
    always_comb begin
        next_pos_o = pos_i;
        if (spawn_i) begin
            next_pos_o = (spawn_val_i > MAX_V) ? MAX_V : spawn_val_i;
        end else if (step_i) begin
            if (sign_i) begin
                if (pos_i == '0) begin
`ifdef POS_WRAP_EN
                    next_pos_o = MAX_V;
`else
                    next_pos_o = pos_i;
`endif
                end else begin
                    next_pos_o = pos_i - ONE_V;
                end
            end else begin
                if (pos_i >= MAX_V) begin
`ifdef POS_WRAP_EN
                    next_pos_o = '0;
`else
                    next_pos_o = pos_i;
`endif
                end else begin
                    next_pos_o = pos_i + ONE_V;
                end
            end
        end
    end

endmodule

// File: rtl/position_tracker.sv
// position_tracker: live (x,y) of one moving object plus redraw request/ack handshake to the draw sequencer.
// Macro POS_WRAP_EN selects wrap-around screen edges; default build saturates at the edges.
module position_tracker
    import asteroids_pkg::*;
#(
    parameter int X_W    = X_W_DEF,
    parameter int Y_W    = Y_W_DEF,
    parameter int X_MAX  = SCREEN_W - 1,
    parameter int Y_MAX  = SCREEN_H - 1,
    parameter int X_INIT = 80,
    parameter int Y_INIT = 60
) (
    input  logic           clk,
    input  logic           reset_n,
    input  logic           move_clk,
    input  logic           delta_x,
    input  logic           delta_y,
    input  logic           sign_x,
    input  logic           sign_y,
    input  logic           spawn,
    input  logic [X_W-1:0] spawn_x,
    input  logic [Y_W-1:0] spawn_y,
    output logic [X_W-1:0] x_pos,
    output logic [Y_W-1:0] y_pos,
    output logic [X_W-1:0] draw_x,
    output logic [Y_W-1:0] draw_y,
    output logic [X_W-1:0] old_x,
    output logic [Y_W-1:0] old_y,
    output logic           redraw_req,
    input  logic           redraw_ack
);

    localparam logic [X_W-1:0] X_INIT_V = X_W'(X_INIT);
    localparam logic [Y_W-1:0] Y_INIT_V = Y_W'(Y_INIT);

    redraw_state_e  state_q, state_d;
    logic [X_W-1:0] x_q, x_d, draw_x_q, draw_x_d, old_x_q, old_x_d;
    logic [Y_W-1:0] y_q, y_d, draw_y_q, draw_y_d, old_y_q, old_y_d;

    axis_step #(.W(X_W), .MAX(X_MAX)) u_step_x (
        .pos_i       (x_q),
        .step_i      (move_clk & delta_x),
        .sign_i      (sign_x),
        .spawn_i     (spawn),
        .spawn_val_i (spawn_x),
        .next_pos_o  (x_d)
    );

    axis_step #(.W(Y_W), .MAX(Y_MAX)) u_step_y (
        .pos_i       (y_q),
        .step_i      (move_clk & delta_y),
        .sign_i      (sign_y),
        .spawn_i     (spawn),
        .spawn_val_i (spawn_y),
        .next_pos_o  (y_d)
    );

    // Redraw FSM: snapshot draw/old on entry to S_REQ and hold them until acked.
    always_comb begin
        state_d    = state_q;
        draw_x_d   = draw_x_q;
        draw_y_d   = draw_y_q;
        old_x_d    = old_x_q;
        old_y_d    = old_y_q;
        redraw_req = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if ((x_q != draw_x_q) || (y_q != draw_y_q)) begin
                    old_x_d  = draw_x_q;
                    old_y_d  = draw_y_q;
                    draw_x_d = x_q;
                    draw_y_d = y_q;
                    state_d  = S_REQ;
                end
            end
            S_REQ: begin
                redraw_req = 1'b1;
                if (redraw_ack) begin
                    state_d = S_ACKED;
                end
            end
            S_ACKED: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: all state uses non-blocking assignments; reset_n is active-high despite its name.
    always_ff @(posedge clk or posedge reset_n) begin
        if (reset_n) begin
            state_q  <= S_IDLE;
            x_q      <= X_INIT_V;
            y_q      <= Y_INIT_V;
            draw_x_q <= X_INIT_V;
            draw_y_q <= Y_INIT_V;
            old_x_q  <= X_INIT_V;
            old_y_q  <= Y_INIT_V;
        end else begin
            state_q  <= state_d;
            x_q      <= x_d;
            y_q      <= y_d;
            draw_x_q <= draw_x_d;
            draw_y_q <= draw_y_d;
            old_x_q  <= old_x_d;
            old_y_q  <= old_y_d;
        end
    end

    assign x_pos  = x_q;
    assign y_pos  = y_q;
    assign draw_x = draw_x_q;
    assign draw_y = draw_y_q;
    assign old_x  = old_x_q;
    assign old_y  = old_y_q;

endmodule

// File: tb/tb_position_tracker.sv
// Scoreboard bench for position_tracker: directed scenarios followed by random movement, spawn and ack traffic.
module tb_position_tracker;

    localparam int X_MAX  = 159;
    localparam int Y_MAX  = 119;
    localparam int X_INIT = 80;
    localparam int Y_INIT = 60;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       move_clk, delta_x, delta_y, sign_x, sign_y, spawn, redraw_ack;
    logic [7:0] spawn_x;
    logic [6:0] spawn_y;
    logic [7:0] x_pos, draw_x, old_x;
    logic [6:0] y_pos, draw_y, old_y;
    logic       redraw_req;

    always #5 clk = ~clk;

    position_tracker dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .move_clk   (move_clk),
        .delta_x    (delta_x),
        .delta_y    (delta_y),
        .sign_x     (sign_x),
        .sign_y     (sign_y),
        .spawn      (spawn),
        .spawn_x    (spawn_x),
        .spawn_y    (spawn_y),
        .x_pos      (x_pos),
        .y_pos      (y_pos),
        .draw_x     (draw_x),
        .draw_y     (draw_y),
        .old_x      (old_x),
        .old_y      (old_y),
        .redraw_req (redraw_req),
        .redraw_ack (redraw_ack)
    );

    typedef struct {
        int dx;
        int dy;
        int ox;
        int oy;
        int at_cyc;
    } req_t;

    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    int   m_x, m_y, m_drawn_x, m_drawn_y, m_earliest;
    bit   m_req_up;
    req_t exp_q[$];
    req_t cur;
    bit   cur_valid = 1'b0;
    bit   prev_req  = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // One coordinate step under the screen-edge rule of this build.
    function automatic int step_axis(input int p, input bit dec, input int mx);
        int n;
        n = dec ? p - 1 : p + 1;
`ifdef POS_WRAP_EN
        if (n < 0)  n = mx;
        if (n > mx) n = 0;
`else
        if (n < 0 || n > mx) n = p;
`endif
        return n;
    endfunction

    task automatic model_reset();
        m_x = X_INIT;  m_y = Y_INIT;
        m_drawn_x = X_INIT; m_drawn_y = Y_INIT;
        m_req_up = 1'b0;
        m_earliest = 0;
        exp_q.delete();
        cur_valid = 1'b0;
    endtask

    // Drive one clock of stimulus and advance the reference model across that edge.
    task automatic drive(input bit mv, input bit dx, input bit sx, input bit dy, input bit sy,
                         input bit sp, input int spx, input int spy, input bit ack);
        move_clk = mv; delta_x = dx; sign_x = sx; delta_y = dy; sign_y = sy;
        spawn = sp; spawn_x = 8'(spx); spawn_y = 7'(spy); redraw_ack = ack;
        @(posedge clk);
        cyc++;
        // A request goes out one edge after the position differs from what was last drawn,
        // and not sooner than two edges after the previous request was acknowledged.
        if (m_req_up) begin
            if (ack) begin
                m_req_up   = 1'b0;
                m_earliest = cyc + 2;
            end
        end else if (cyc >= m_earliest && (m_x != m_drawn_x || m_y != m_drawn_y)) begin
            exp_q.push_back('{dx: m_x, dy: m_y, ox: m_drawn_x, oy: m_drawn_y, at_cyc: cyc});
            m_drawn_x = m_x;
            m_drawn_y = m_y;
            m_req_up  = 1'b1;
        end
        if (sp) begin
            m_x = (spx > X_MAX) ? X_MAX : spx;
            m_y = (spy > Y_MAX) ? Y_MAX : spy;
        end else if (mv) begin
            if (dx) m_x = step_axis(m_x, sx, X_MAX);
            if (dy) m_y = step_axis(m_y, sy, Y_MAX);
        end
        #1;
    endtask

    task automatic idle(input bit ack);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, ack);
    endtask

    // Monitor: compares live position every cycle and each presented request against the scoreboard.
    always @(negedge clk) begin
        if (reset_n) begin
            prev_req = 1'b0;
        end else begin
            check("req_level", int'(redraw_req), int'(m_req_up));
            check("x_pos", int'(x_pos), m_x);
            check("y_pos", int'(y_pos), m_y);
            if (redraw_req && !prev_req) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    cur_valid = 1'b0;
                    $display("FAIL unexpected_req: request raised with none expected (cycle %0d)", cyc);
                end else begin
                    cur = exp_q.pop_front();
                    cur_valid = 1'b1;
                    check("req_latency", cyc, cur.at_cyc);
                end
            end
            if (redraw_req && cur_valid) begin
                check("draw_x", int'(draw_x), cur.dx);
                check("draw_y", int'(draw_y), cur.dy);
                check("old_x", int'(old_x), cur.ox);
                check("old_y", int'(old_y), cur.oy);
            end
            prev_req = redraw_req;
        end
    end

    initial begin
        int x_lo_exp, x_hi_exp, y_lo_exp;
        int waited;
`ifdef POS_WRAP_EN
        x_lo_exp = X_MAX; x_hi_exp = 0;     y_lo_exp = Y_MAX;
`else
        x_lo_exp = 0;     x_hi_exp = X_MAX; y_lo_exp = 0;
`endif
        reset_n = 1'b1;
        move_clk = 0; delta_x = 0; delta_y = 0; sign_x = 0; sign_y = 0;
        spawn = 0; spawn_x = '0; spawn_y = '0; redraw_ack = 0;
        model_reset();
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b0;

        // Reset state held through idle cycles.
        repeat (10) idle(1'b0);
        check("reset_x", int'(x_pos), X_INIT);
        check("reset_y", int'(y_pos), Y_INIT);
        check("reset_req", int'(redraw_req), 0);

        // Diagonal tick: +x, -y.
        drive(1, 1, 0, 1, 1, 0, 0, 0, 0);
        check("tick_x", int'(x_pos), 81);
        check("tick_y", int'(y_pos), 59);
        check("tick_req_lat", int'(redraw_req), 0);
        idle(1'b0);
        check("req1", int'(redraw_req), 1);
        check("req1_draw_x", int'(draw_x), 81);
        check("req1_draw_y", int'(draw_y), 59);
        check("req1_old_x", int'(old_x), 80);
        check("req1_old_y", int'(old_y), 60);

        // Moves while unacked coalesce; draw/old stay frozen.
        repeat (3) drive(1, 1, 0, 0, 0, 0, 0, 0, 0);
        check("frozen_draw_x", int'(draw_x), 81);
        check("frozen_old_x", int'(old_x), 80);
        check("live_x", int'(x_pos), 84);
        idle(1'b0);
        idle(1'b1);
        check("acked_low", int'(redraw_req), 0);
        idle(1'b0);
        check("gap_low", int'(redraw_req), 0);
        idle(1'b0);
        check("req2", int'(redraw_req), 1);
        check("req2_draw_x", int'(draw_x), 84);
        check("req2_draw_y", int'(draw_y), 59);
        check("req2_old_x", int'(old_x), 81);
        check("req2_old_y", int'(old_y), 59);
        idle(1'b1);
        idle(1'b0);
        idle(1'b0);

        // Screen edges and spawn clamping.
        drive(0, 0, 0, 0, 0, 1, 0, 0, 0);
        check("spawn0_x", int'(x_pos), 0);
        check("spawn0_y", int'(y_pos), 0);
        drive(1, 1, 1, 0, 0, 0, 0, 0, 0);
        check("x_below_0", int'(x_pos), x_lo_exp);
        drive(1, 0, 0, 1, 1, 0, 0, 0, 0);
        check("y_below_0", int'(y_pos), y_lo_exp);
        drive(0, 0, 0, 0, 0, 1, 200, 127, 0);
        check("clamp_x", int'(x_pos), X_MAX);
        check("clamp_y", int'(y_pos), Y_MAX);
        drive(1, 1, 0, 0, 0, 0, 0, 0, 0);
        check("x_above_max", int'(x_pos), x_hi_exp);
        drive(1, 1, 0, 1, 0, 1, 10, 20, 0);
        check("spawn_wins_x", int'(x_pos), 10);
        check("spawn_wins_y", int'(y_pos), 20);
        repeat (6) idle(1'b1);

        // Asynchronous reset in the middle of a handshake.
        drive(1, 0, 0, 1, 0, 0, 0, 0, 0);
        waited = 0;
        while (!redraw_req && waited < 10) begin
            idle(1'b0);
            waited++;
        end
        check("pre_reset_req", int'(redraw_req), 1);
        @(negedge clk);
        #2 reset_n = 1'b1;
        #1;
        check("async_req", int'(redraw_req), 0);
        check("async_x", int'(x_pos), X_INIT);
        check("async_y", int'(y_pos), Y_INIT);
        check("async_draw_x", int'(draw_x), X_INIT);
        check("async_draw_y", int'(draw_y), Y_INIT);
        check("async_old_x", int'(old_x), X_INIT);
        check("async_old_y", int'(old_y), Y_INIT);
        model_reset();
        @(posedge clk);
        #1 reset_n = 1'b0;
        repeat (3) idle(1'b0);

        // Random traffic.
        for (int i = 0; i < 600; i++) begin
            drive($urandom_range(0, 2) == 0, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                  $urandom_range(0, 24) == 0, int'($urandom_range(0, 255)), int'($urandom_range(0, 127)),
                  $urandom_range(0, 2) == 0);
        end

        // Drain: ack everything still outstanding.
        repeat (20) idle(1'b1);
        check("queue_empty", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
